// File: rtl/add_nbits_pipe.sv
// Segmented, pipelined WIDTH-bit adder/subtractor: one SEG_WIDTH slice per stage, coherent result after NSEG cycles.
// Define ADD_PIPE_OVF_EN to add the o_overflow port (signed overflow, aligned with o_data).
module add_nbits_pipe #(
  parameter int WIDTH     = 27,
  parameter int SEG_WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_en,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_data_one,
  input  logic [WIDTH-1:0] i_data_two,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

  // Subtraction is a + ~b + 1; the external carry only matters for adds.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = i_sub ? ~i_data_two : i_data_two;
  assign c_eff = i_sub | i_carry;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam int LO = gi * SEG_WIDTH;
      localparam int HI = (gi == NSEG - 1) ? WIDTH - 1 : LO + SEG_WIDTH - 1;
      localparam int SW = HI - LO + 1;

      // Operands still to be added (bits LO and up), carry and valid entering this stage.
      logic [WIDTH-1:LO] in_a;
      logic [WIDTH-1:LO] in_b;
      logic              in_c;
      logic              in_v;
      logic [SW:0]       seg_sum;
      logic [HI:0]       res_next;
      logic [HI:0]       res_reg;
      logic              carry_reg;
      logic              valid_reg;

      if (gi == 0) begin : g_src
        assign in_a     = i_data_one;
        assign in_b     = b_eff;
        assign in_c     = c_eff;
        assign in_v     = i_valid;
        assign res_next = seg_sum[SW-1:0];
      end else begin : g_src
        assign in_a     = g_stage[gi-1].g_fwd.a_reg;
        assign in_b     = g_stage[gi-1].g_fwd.b_reg;
        assign in_c     = g_stage[gi-1].carry_reg;
        assign in_v     = g_stage[gi-1].valid_reg;
        // Lower result segments ride along so the whole word leaves together.
        assign res_next = {seg_sum[SW-1:0], g_stage[gi-1].res_reg};
      end

      assign seg_sum = {1'b0, in_a[HI:LO]} + {1'b0, in_b[HI:LO]} + {{SW{1'b0}}, in_c};

      // Data registers load only for real operations, so the last stage holds the last valid result.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          res_reg   <= '0;
        end else if (i_en) begin
          valid_reg <= in_v;
          if (in_v) begin
            carry_reg <= seg_sum[SW];
            res_reg   <= res_next;
          end
        end
      end

      if (gi < NSEG - 1) begin : g_fwd
        // Upper operand bits skewed forward to the stage that consumes them.
        logic [WIDTH-1:HI+1] a_reg;
        logic [WIDTH-1:HI+1] b_reg;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (i_en && in_v) begin
            a_reg <= in_a[WIDTH-1:HI+1];
            b_reg <= in_b[WIDTH-1:HI+1];
          end
        end
      end else begin : g_last
`ifdef ADD_PIPE_OVF_EN
        logic ovf_reg;

        // Sign bits of both (post-inversion) operands agree but the result sign differs.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            ovf_reg <= 1'b0;
          end else if (i_en && in_v) begin
            ovf_reg <= (in_a[WIDTH-1] == in_b[WIDTH-1]) && (seg_sum[SW-1] != in_a[WIDTH-1]);
          end
        end
`endif
      end
    end
  endgenerate

  assign o_valid = g_stage[NSEG-1].valid_reg;
  assign o_data  = g_stage[NSEG-1].res_reg;
  assign o_carry = g_stage[NSEG-1].carry_reg;
`ifdef ADD_PIPE_OVF_EN
  assign o_overflow = g_stage[NSEG-1].g_last.ovf_reg;
`endif

endmodule

// File: tb/tb_add_nbits_pipe.sv
// Self-checking bench for add_nbits_pipe (WIDTH=27, SEG_WIDTH=9): directed table, corner sequences, random vs model.
// Build with ADD_PIPE_OVF_EN defined to also check o_overflow.
module tb_add_nbits_pipe;
  localparam int W    = 27;
  localparam int NSEG = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         valid = 1'b0;
  logic         en = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] one = '0;
  logic [W-1:0] two = '0;
  logic         o_valid;
  logic         o_carry;
  logic [W-1:0] o_data;
`ifdef ADD_PIPE_OVF_EN
  logic         o_overflow;
`endif

  add_nbits_pipe #(.WIDTH(W), .SEG_WIDTH(9)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_en       (en),
    .i_sub      (sub),
    .i_data_one (one),
    .i_data_two (two),
    .i_carry    (cin),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_carry    (o_carry)
`ifdef ADD_PIPE_OVF_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         c;
    logic         ov;
  } res_t;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] d;
    logic         c;
    logic         ov;
  } vec_t;

  res_t pipe_q [NSEG];
  res_t exp_last;
  logic exp_valid;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic longint sval(logic [W-1:0] x);
    return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic res_t calc(logic s, logic [W-1:0] a, logic [W-1:0] b, logic ci);
    res_t   r;
    longint t;
    longint st;
    r.v = 1'b1;
    if (s) begin
      t   = longint'(a) - longint'(b);
      r.c = (longint'(a) >= longint'(b));
      st  = sval(a) - sval(b);
    end else begin
      t   = longint'(a) + longint'(b) + longint'(ci);
      r.c = (t >= (longint'(1) << W));
      st  = sval(a) + sval(b) + longint'(ci);
    end
    r.d  = t[W-1:0];
    r.ov = (st > ((longint'(1) << (W-1)) - 1)) || (st < -(longint'(1) << (W-1)));
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NSEG; k++) pipe_q[k] = '0;
    exp_last  = '0;
    exp_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (en) begin
      for (int k = NSEG - 1; k > 0; k--) pipe_q[k] = pipe_q[k-1];
      pipe_q[0] = valid ? calc(sub, one, two, cin) : '0;
      exp_valid = pipe_q[NSEG-1].v;
      if (exp_valid) exp_last = pipe_q[NSEG-1];
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'(exp_valid));
    chk({tag, ".data"},  64'(o_data),  64'(exp_last.d));
    chk({tag, ".carry"}, 64'(o_carry), 64'(exp_last.c));
`ifdef ADD_PIPE_OVF_EN
    chk({tag, ".ovf"},   64'(o_overflow), 64'(exp_last.ov));
`endif
  endtask

  task automatic step(logic v, logic e, logic s, logic [W-1:0] a, logic [W-1:0] b, logic ci, string tag);
    valid = v; en = e; sub = s; one = a; two = b; cin = ci;
    @(posedge clk);
    model_edge();
    #1;
    check_out(tag);
  endtask

  task automatic idle(string tag);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, tag);
  endtask

  vec_t         vecs [10];
  logic [W-1:0] seen_q [$];
  int           first_i;
  int           last_i;
  logic         stall_v [8];
  logic [W-1:0] stall_d [8];
  logic [W-1:0] corner [5];

  initial begin
    vecs[0] = '{1'b0, 27'h7FFFFFF, 27'h0,       1'b1, 27'h0,       1'b1, 1'b0};
    vecs[1] = '{1'b1, 27'h5,       27'h7,       1'b0, 27'h7FFFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 27'h7,       27'h5,       1'b0, 27'h2,       1'b1, 1'b0};
    vecs[3] = '{1'b0, 27'h3FFFFFF, 27'h1,       1'b0, 27'h4000000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 27'h4000000, 27'h1,       1'b0, 27'h3FFFFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 27'h1FF,     27'h1,       1'b0, 27'h200,     1'b0, 1'b0};
    vecs[6] = '{1'b0, 27'h3FFFF,   27'h1,       1'b1, 27'h40001,   1'b0, 1'b0};
    vecs[7] = '{1'b0, 27'h7FFFFFF, 27'h7FFFFFF, 1'b1, 27'h7FFFFFF, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 27'hA,       27'h3,       1'b1, 27'h7,       1'b1, 1'b0};
    vecs[9] = '{1'b0, 27'h0,       27'h0,       1'b1, 27'h1,       1'b0, 1'b0};

    // Reset state
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_out("reset");
    #14 rst_n = 1'b1;

    // Directed table: each op isolated, result checked three cycles after acceptance
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ci, "tbl.accept");
      idle("tbl.wait1");
      idle("tbl.wait2");
      chk("tbl.valid", 64'(o_valid), 64'd1);
      chk("tbl.data",  64'(o_data),  64'(vecs[i].d));
      chk("tbl.carry", 64'(o_carry), 64'(vecs[i].c));
`ifdef ADD_PIPE_OVF_EN
      chk("tbl.ovf",   64'(o_overflow), 64'(vecs[i].ov));
`endif
      $display("vec %0d: sub=%0d a=%h b=%h cin=%0d -> data=%h carry=%0d", i, vecs[i].s,
               vecs[i].a, vecs[i].b, vecs[i].ci, o_data, o_carry);
      idle("tbl.drain");
    end

    // Four back-to-back adds
    seen_q.delete();
    first_i = -1;
    last_i  = -1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b1, 1'b1, 1'b0, W'(i + 1), W'(i + 1), 1'b0, "b2b");
      else       idle("b2b");
      if (o_valid) begin
        seen_q.push_back(o_data);
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    chk("b2b.count", 64'(seen_q.size()), 64'd4);
    chk("b2b.span",  64'(last_i - first_i), 64'd3);
    for (int i = 0; i < seen_q.size(); i++) chk("b2b.order", 64'(seen_q[i]), 64'(2 * (i + 1)));

    // Stall with two ops in flight: results two cycles late, frozen outputs meanwhile
    stall_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    stall_d = '{27'd8, 27'd8, 27'd8, 27'd8, 27'd30, 27'd300, 27'd300, 27'd300};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 1'b0, W'(10),  W'(20),  1'b0, "stall");
        1:       step(1'b1, 1'b1, 1'b0, W'(100), W'(200), 1'b0, "stall");
        2, 3:    step(1'b1, 1'b0, 1'b0, W'(7),   W'(7),   1'b0, "stall");
        default: idle("stall");
      endcase
      chk("stall.valid", 64'(o_valid), 64'(stall_v[i]));
      chk("stall.data",  64'(o_data),  64'(stall_d[i]));
    end

    // Reset with two ops in flight
    step(1'b1, 1'b1, 1'b0, W'(5), W'(5), 1'b0, "rst.accept");
    step(1'b1, 1'b1, 1'b0, W'(6), W'(6), 1'b0, "rst.accept");
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.data",  64'(o_data),  64'd0);
    chk("rst.carry", 64'(o_carry), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle("rst.after");
      chk("rst.novalid", 64'(o_valid), 64'd0);
    end
    step(1'b1, 1'b1, 1'b0, W'(9), W'(9), 1'b0, "rst.new");
    idle("rst.new");
    idle("rst.new");
    chk("rst.newdata", 64'(o_data), 64'd18);

    // Randomized traffic against the reference model
    corner = '{27'h7FFFFFF, 27'h0, 27'h4000000, 27'h3FFFFFF, 27'h1FF};
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = ($urandom % 6 == 0) ? corner[$urandom % 5] : W'($urandom);
      rb = ($urandom % 6 == 0) ? corner[$urandom % 5] : W'($urandom);
      step(($urandom % 4) != 0, ($urandom % 5) != 0, $urandom % 2 == 1, ra, rb,
           $urandom % 2 == 1, "rand");
    end
    for (int i = 0; i < NSEG; i++) idle("rand.drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/add_nbits_pipe.md
ADD_NBITS_PIPE -- requirements
Module: add_nbits_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 27, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have parameter SEG_WIDTH, default 9, bits added per pipeline stage; legal range 1..WIDTH.
REQ-003 SHALL derive NSEG = ceil(WIDTH/SEG_WIDTH); last segment width = WIDTH - (NSEG-1)*SEG_WIDTH.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  operands/mode valid this cycle.
REQ-008 i_en  input  1  pipeline advance enable; 0 = stall.
REQ-009 i_sub  input  1  0 = add, 1 = subtract.
REQ-010 i_data_one  input  WIDTH  first operand.
REQ-011 i_data_two  input  WIDTH  second operand.
REQ-012 i_carry  input  1  carry-in, used in add mode only.
REQ-013 o_valid  output  1  result valid this cycle.
REQ-014 o_data  output  WIDTH  sum/difference.
REQ-015 o_carry  output  1  carry-out of bit WIDTH-1.
REQ-016 o_overflow  output  1  signed overflow; present only with ADD_PIPE_OVF_EN.

Function
REQ-017 Add: o_data = (one + two + i_carry) mod 2^WIDTH; o_carry = bit WIDTH of the full sum.
REQ-018 Subtract: two bitwise inverted, carry-in forced 1, i_carry ignored; o_carry = 1 means no borrow.
REQ-019 Stage k (0..NSEG-1) SHALL add segment k using the registered carry from stage k-1; stage 0 uses the effective carry-in.
REQ-020 Upper operand segments SHALL be skewed and lower result segments deskewed so each result emerges whole, coherent, in one cycle.
REQ-021 Operation accepted when i_valid=1 and i_en=1; result appears on o_valid exactly NSEG enabled cycles later.
REQ-022 Throughput one operation per enabled cycle; results in acceptance order; no loss or duplication.
REQ-023 i_valid=1 with i_en=0 SHALL NOT be accepted; caller holds or re-presents.
REQ-024 i_en=0 SHALL freeze all pipeline registers including the valid chain; outputs hold.
REQ-025 i_valid=0 with i_en=1 SHALL insert a bubble; bubble reaches output as o_valid=0.
REQ-026 o_data, o_carry, o_overflow SHALL update only when a valid result emerges; otherwise hold last valid result.
REQ-027 NSEG=1 SHALL degenerate to a single registered adder, latency 1.

Reset
REQ-028 i_rst_n=0 SHALL immediately clear every register: o_valid=0, o_data=0, o_carry=0, o_overflow=0.
REQ-029 Operations in flight at reset SHALL be discarded; none emerge after release.
REQ-030 First acceptance possible on first rising edge with i_rst_n=1.

Configuration
REQ-031 Macro ADD_PIPE_OVF_EN defined: o_overflow port exists; =1 when operand sign bits (after subtract inversion) are equal and result sign differs; aligned with o_data.
REQ-032 Macro undefined: o_overflow port and its sign-tracking registers absent; all other behaviour identical.

Verification (WIDTH=27, SEG_WIDTH=9, latency 3)
REQ-033 one=0x7FFFFFF, two=0, i_carry=1, add -> 3 cycles later o_valid=1, o_data=0, o_carry=1.
REQ-034 Four back-to-back adds (1+1, 2+2, 3+3, 4+4) -> o_valid high 4 consecutive cycles, o_data 2,4,6,8.
REQ-035 Subtract 5-7 -> o_data=0x7FFFFFE, o_carry=0; subtract 7-5 -> o_data=2, o_carry=1.
REQ-036 i_en=0 for 2 cycles with 2 ops in flight -> outputs frozen, results arrive 2 cycles late, in order, once each.
REQ-037 Reset pulse with 2 ops in flight -> o_valid=0 and o_data=0 immediately, no o_valid after release until new acceptance.
REQ-038 With ADD_PIPE_OVF_EN: 0x3FFFFFF+1 add -> o_overflow=1, o_data=0x4000000; 0x4000000-1 subtract -> o_overflow=1.
